sample_readout: RTL and testbench
=================================

// Module: sample_readout
// PURPOSE
//  Reader side of the per-channel 8-bit sample RAMs. The oscilloscope acquisition logic fills these RAMs
//  circularly and flags data_ready. On request, this block walks the RAMs starting at the first
//  pre-trigger sample, one enabled channel at a time, and streams bytes over a valid/ready byte interface
//  to the host link (serial/USB TX). It runs on the main FPGA clock, the same domain as data_ready.
// PARAMETERS
//  ram_width  10  RAM address width; RAM depth = 2**ram_width
//  RD_LAT     2   cycles from rden/rdaddress to valid rddataN (fixed, no stall on RAM side)
// PORTS
//  clk                    in   1          main clock; all logic posedge clk
//  reset                  in   1          asynchronous, active-high
//  start                  in   1          1-cycle request to read out one event
//  data_ready             in   1          acquisition complete, RAM contents stable
//  wraddress_triggerpoint in   ram_width  write address at trigger
//  triggerpoint           in   ram_width  number of pre-trigger samples
//  nsmp                   in   ram_width  samples per channel to send
//  chanmask               in   4          bit i set = send channel i+1
//  rden                   out  1          RAM read enable
//  rdaddress              out  ram_width  RAM read address (shared by all 4 RAMs)
//  rddata1..rddata4       in   8 each     RAM read data, valid RD_LAT cycles after rden
//  tdata                  out  8          output byte
//  tvalid                 out  1          tdata valid
//  tready                 in   1          sink accepts when tvalid&tready
//  tlast                  out  1          marks last byte of the event
//  busy                   out  1          readout in progress (state != IDLE)
//  done                   out  1          1-cycle pulse when event fully sent
// BEHAVIOUR
//  Reset values: rden=0, rdaddress=0, tvalid=0, tdata=0, tlast=0, busy=0, done=0, FIFO empty, state IDLE.
//  Reset asserted mid-event: readout aborts, in-flight RAM reads are discarded, no partial bytes afterwards.
//  States:
//   IDLE: on start, latch base=wraddress_triggerpoint-triggerpoint (mod 2**ram_width), nsmp, chanmask.
//         Go to WAITRDY. start while busy is ignored.
//   WAITRDY: wait until data_ready=1. Then chanmask==0 or nsmp==0 -> DONE with no bytes sent;
//            else ch = lowest set bit of chanmask, addr=base, cnt=0 -> READ.
//   READ: issue rden=1, rdaddress=addr when credit allows, then addr++ (wraps 2**ram_width-1 -> 0) and cnt++.
//         When cnt reaches nsmp: next set channel bit -> addr=base, cnt=0, stay in READ; none left -> DRAIN.
//   DRAIN: wait until all issued reads are returned and the FIFO is empty with its last byte accepted
//          -> DONE.
//   DONE: done=1 for one cycle, then IDLE.
//  Data path: a channel tag is delayed RD_LAT cycles alongside rden. On return, the matching rddataN is
//   selected and pushed into an output FIFO of depth RD_LAT+2. Credit rule: a read is issued only if
//   (FIFO occupancy + reads in flight) < RD_LAT+2, so the FIFO never overflows and no read is lost
//   under any tready pattern.
//  With sustained tready=1: 1 byte/cycle. First tvalid comes RD_LAT+1 cycles after READ entry.
//  tdata/tvalid/tlast are held stable while tvalid&~tready. tlast=1 only on the final byte
//   (last sample of the highest enabled channel).
//  Byte order: channels ascending (1..4). Within a channel, addresses base, base+1, ... modulo depth.
//  Inputs latched at start are not re-sampled during readout; data_ready falling mid-event is ignored.
// TESTING
//  T1: ram_width=10, wraddress_triggerpoint=5, triggerpoint=10, nsmp=4, chanmask=0001, tready=1
//      -> addresses 1019,1020,1021,1022 on RAM1; 4 bytes, tlast on 4th, done 1 cycle after.
//  T2: base=1022, nsmp=4 -> address sequence 1022,1023,0,1 (wrap).
//  T3: chanmask=1010, nsmp=3 -> 3 bytes from rddata2, then 3 from rddata4. 6 bytes total, tlast on 6th.
//  T4: nsmp=16, chanmask=1111, tready random 30% duty -> 64 bytes in order, none dropped or duplicated,
//      tdata stable while stalled.
//  T5: chanmask=0000 or nsmp=0 -> zero tvalid cycles, done pulses once. start while busy -> ignored.
//  T6: start with data_ready=0, raise data_ready 20 cycles later -> no rden before data_ready;
//      reset in mid-READ -> all outputs return to reset values immediately, next start works normally.

Source files
------------

// File: rtl/sample_readout.sv
// sample_readout: reader side of the four per-channel 8-bit sample RAMs.
// Walks each enabled channel from the first pre-trigger sample and streams
// the bytes over a valid/ready byte interface, channels in ascending order.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   start                       1-cycle request to read out one event
//   data_ready                  acquisition complete, RAM contents stable
//   wraddress_triggerpoint      write address at trigger
//   triggerpoint                number of pre-trigger samples
//   nsmp                        samples per channel to send
//   chanmask                    bit i set = send channel i+1
//   rden, rdaddress             shared RAM read port
//   rddata1..rddata4            RAM read data, valid RD_LAT cycles after rden
//   tdata, tvalid, tready, tlast  output byte stream
//   busy                        readout in progress
//   done                        1-cycle pulse when the event is fully sent
module sample_readout #(
    parameter int unsigned ram_width = 10,
    parameter int unsigned RD_LAT    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 data_ready,
    input  logic [ram_width-1:0] wraddress_triggerpoint,
    input  logic [ram_width-1:0] triggerpoint,
    input  logic [ram_width-1:0] nsmp,
    input  logic [3:0]           chanmask,
    output logic                 rden,
    output logic [ram_width-1:0] rdaddress,
    input  logic [7:0]           rddata1,
    input  logic [7:0]           rddata2,
    input  logic [7:0]           rddata3,
    input  logic [7:0]           rddata4,
    output logic [7:0]           tdata,
    output logic                 tvalid,
    input  logic                 tready,
    output logic                 tlast,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned Depth = RD_LAT + 2;
    localparam int unsigned PtrW  = $clog2(Depth);
    localparam int unsigned CntW  = $clog2(Depth + 1);

    typedef enum logic [2:0] {StIdle, StWaitRdy, StRead, StDrain, StDone} state_e;

    state_e               state_q, state_d;
    logic [ram_width-1:0] base_q, nsmp_q, addr_q, addr_d, cnt_q, cnt_d;
    logic [3:0]           mask_q;
    logic [1:0]           ch_q, ch_d;

    // Read-return pipeline: channel tag and last flag travel alongside rden.
    logic [RD_LAT-1:0]    pipe_vld_q, pipe_last_q;
    logic [1:0]           pipe_ch_q [RD_LAT];

    logic [7:0]           fifo_data_q [Depth];
    logic [Depth-1:0]     fifo_last_q;
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      fifo_cnt_q;

    logic                 issue, issue_last, push, pop, credit_ok, last_smp, has_next;
    logic [CntW-1:0]      inflight;
    logic [1:0]           first_ch, next_ch;
    logic [7:0]           ret_data;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Lowest enabled channel overall, and lowest enabled channel above ch_q.
    always_comb begin
        first_ch = 2'd0;
        next_ch  = 2'd0;
        has_next = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (mask_q[i]) begin
                first_ch = 2'(i);
                if (i > int'(ch_q)) begin
                    next_ch  = 2'(i);
                    has_next = 1'b1;
                end
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CntW'(pipe_vld_q[i]);
        end
    end

    // Reserve a FIFO slot for every read in flight so no returned byte is lost.
    assign credit_ok = ({1'b0, fifo_cnt_q} + {1'b0, inflight}) < (CntW + 1)'(Depth);
    assign last_smp  = (cnt_q == nsmp_q - ram_width'(1));
    assign push      = pipe_vld_q[RD_LAT-1];
    assign pop       = tvalid & tready;

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        issue      = 1'b0;
        issue_last = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StWaitRdy;
            end
            StWaitRdy: begin
                if (data_ready) begin
                    if (mask_q == 4'b0000 || nsmp_q == '0) begin
                        state_d = StDone;
                    end else begin
                        ch_d    = first_ch;
                        addr_d  = base_q;
                        cnt_d   = '0;
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (last_smp) begin
                        if (has_next) begin
                            ch_d   = next_ch;
                            addr_d = base_q;
                            cnt_d  = '0;
                        end else begin
                            issue_last = 1'b1;
                            state_d    = StDrain;
                        end
                    end else begin
                        addr_d = addr_q + 1'b1;
                        cnt_d  = cnt_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                // Leave as soon as the final byte is being accepted this cycle.
                if (inflight == '0 &&
                    (fifo_cnt_q == '0 || (fifo_cnt_q == CntW'(1) && pop))) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            ch_q    <= 2'd0;
            addr_q  <= '0;
            cnt_q   <= '0;
            base_q  <= '0;
            nsmp_q  <= '0;
            mask_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            if (state_q == StIdle && start) begin
                base_q <= wraddress_triggerpoint - triggerpoint;
                nsmp_q <= nsmp;
                mask_q <= chanmask;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_ch_q[i] <= 2'd0;
        end else begin
            pipe_vld_q[0]  <= issue;
            pipe_last_q[0] <= issue_last;
            pipe_ch_q[0]   <= ch_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_last_q[i] <= pipe_last_q[i-1];
                pipe_ch_q[i]   <= pipe_ch_q[i-1];
            end
        end
    end

    always_comb begin
        ret_data = rddata1;
        unique case (pipe_ch_q[RD_LAT-1])
            2'd0: ret_data = rddata1;
            2'd1: ret_data = rddata2;
            2'd2: ret_data = rddata3;
            2'd3: ret_data = rddata4;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) fifo_data_q[i] <= 8'h00;
            fifo_last_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= ret_data;
                fifo_last_q[wr_ptr_q] <= pipe_last_q[RD_LAT-1];
                wr_ptr_q              <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            fifo_cnt_q <= fifo_cnt_q + CntW'(push) - CntW'(pop);
        end
    end

    assign rden      = issue;
    assign rdaddress = addr_q;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign tvalid    = (fifo_cnt_q != '0);
    assign tdata     = fifo_data_q[rd_ptr_q];
    assign tlast     = tvalid & fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_sample_readout.sv
// tb_sample_readout: directed bench for sample_readout with a 2-cycle RAM model.
module tb_sample_readout;

    localparam int RdLat = 2;

    logic       clk = 1'b0;
    logic       reset, start, data_ready, tready;
    logic [9:0] wraddress_triggerpoint, triggerpoint, nsmp, rdaddress;
    logic [3:0] chanmask;
    logic       rden, tvalid, tlast, busy, done;
    logic [7:0] rddata1, rddata2, rddata3, rddata4, tdata;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sample_readout #(.ram_width(10), .RD_LAT(RdLat)) dut (
        .clk(clk), .reset(reset), .start(start), .data_ready(data_ready),
        .wraddress_triggerpoint(wraddress_triggerpoint), .triggerpoint(triggerpoint),
        .nsmp(nsmp), .chanmask(chanmask), .rden(rden), .rdaddress(rdaddress),
        .rddata1(rddata1), .rddata2(rddata2), .rddata3(rddata3), .rddata4(rddata4),
        .tdata(tdata), .tvalid(tvalid), .tready(tready), .tlast(tlast),
        .busy(busy), .done(done)
    );

    // RAM contents: each channel holds a distinct pattern derived from the address.
    function automatic logic [7:0] mk(input int ch, input logic [9:0] a);
        return a[7:0] ^ 8'(29 * (ch + 1));
    endfunction

    logic [9:0] pa1 = '0, pa2 = '0;
    always @(posedge clk) begin
        pa1 <= rdaddress;
        pa2 <= pa1;
    end
    assign rddata1 = mk(0, pa2);
    assign rddata2 = mk(1, pa2);
    assign rddata3 = mk(2, pa2);
    assign rddata4 = mk(3, pa2);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor (sampled on the falling edge).
    logic [9:0] got_addr[$];
    logic [7:0] got_data[$];
    logic       got_last[$];
    int  cyc = 0, done_ev = 0, tv_cycles = 0, rden_first = 0, tv_first = 0;
    int  done_cyc = 0, last_acc_cyc = 0;
    bit  rden_seen = 0, tv_seen = 0, stall_prev = 0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            stall_prev = 0;
        end else begin
            if (rden) begin
                got_addr.push_back(rdaddress);
                if (!rden_seen) rden_first = cyc;
                rden_seen = 1;
            end
            if (tvalid) begin
                tv_cycles++;
                if (!tv_seen) tv_first = cyc;
                tv_seen = 1;
            end
            if (tvalid && tready) begin
                got_data.push_back(tdata);
                got_last.push_back(tlast);
                if (tlast) last_acc_cyc = cyc;
            end
            if (done) begin
                done_ev++;
                done_cyc = cyc;
            end
            if (stall_prev) begin
                chk("stall_tvalid", 32'(tvalid), 32'd1);
                chk("stall_tdata", 32'(tdata), 32'(prev_data));
                chk("stall_tlast", 32'(tlast), 32'(prev_last));
            end
            stall_prev = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
        end
    end

    task automatic clear_mon();
        got_addr.delete();
        got_data.delete();
        got_last.delete();
        rden_seen = 0;
        tv_seen   = 0;
        tv_cycles = 0;
        done_ev   = 0;
    endtask

    task automatic start_event(input logic [9:0] wtp, input logic [9:0] tp,
                               input logic [9:0] n, input logic [3:0] m);
        @(posedge clk);
        #1;
        clear_mon();
        wraddress_triggerpoint = wtp;
        triggerpoint           = tp;
        nsmp                   = n;
        chanmask               = m;
        start                  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd, input string tag);
        int c = 0;
        while (done_ev == 0 && c < budget) begin
            @(posedge clk);
            #1;
            tready = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
            c++;
        end
        chk($sformatf("%s_done_seen", tag), 32'(done_ev != 0), 32'd1);
        tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_event(input string tag, input logic [9:0] base, input int n,
                               input logic [3:0] m);
        logic [9:0] ea[$];
        logic [7:0] eb[$];
        logic [9:0] a;
        int tot;
        for (int ch = 0; ch < 4; ch++) begin
            if (m[ch]) begin
                for (int k = 0; k < n; k++) begin
                    a = base + 10'(k);
                    ea.push_back(a);
                    eb.push_back(mk(ch, a));
                end
            end
        end
        tot = eb.size();
        chk($sformatf("%s_nbytes", tag), 32'(got_data.size()), 32'(tot));
        chk($sformatf("%s_nreads", tag), 32'(got_addr.size()), 32'(tot));
        for (int i = 0; i < tot; i++) begin
            if (i < got_data.size()) begin
                chk($sformatf("%s_byte%0d", tag, i), 32'(got_data[i]), 32'(eb[i]));
                chk($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(i == tot - 1));
            end
            if (i < got_addr.size())
                chk($sformatf("%s_addr%0d", tag, i), 32'(got_addr[i]), 32'(ea[i]));
        end
        chk($sformatf("%s_done_pulses", tag), 32'(done_ev), 32'd1);
    endtask

    task automatic check_reset(input string tag);
        chk($sformatf("%s_rden", tag), 32'(rden), 32'd0);
        chk($sformatf("%s_rdaddress", tag), 32'(rdaddress), 32'd0);
        chk($sformatf("%s_tvalid", tag), 32'(tvalid), 32'd0);
        chk($sformatf("%s_tdata", tag), 32'(tdata), 32'd0);
        chk($sformatf("%s_tlast", tag), 32'(tlast), 32'd0);
        chk($sformatf("%s_busy", tag), 32'(busy), 32'd0);
        chk($sformatf("%s_done", tag), 32'(done), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; data_ready = 1'b1; tready = 1'b1;
        wraddress_triggerpoint = '0; triggerpoint = '0; nsmp = '0; chanmask = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        reset = 1'b0;

        // T1: base 5-10 = 1019, one channel, latency and done timing.
        start_event(10'd5, 10'd10, 10'd4, 4'b0001);
        wait_done(200, 1'b0, "t1");
        check_event("t1", 10'd1019, 4, 4'b0001);
        chk("t1_first_tvalid_latency", 32'(tv_first - rden_first), 32'(RdLat + 1));
        chk("t1_done_after_tlast", 32'(done_cyc - last_acc_cyc), 32'd1);
        chk("t1_tvalid_cycles", 32'(tv_cycles), 32'd4);

        // T2: address wrap 1022,1023,0,1.
        start_event(10'd1022, 10'd0, 10'd4, 4'b0001);
        wait_done(200, 1'b0, "t2");
        check_event("t2", 10'd1022, 4, 4'b0001);

        // T3: channels 2 and 4, base 100-30 = 70.
        start_event(10'd100, 10'd30, 10'd3, 4'b1010);
        wait_done(200, 1'b0, "t3");
        check_event("t3", 10'd70, 3, 4'b1010);

        // T4: all channels, 16 samples, base 3-10 = 1017, sink ready ~30% of cycles.
        start_event(10'd3, 10'd10, 10'd16, 4'b1111);
        wait_done(3000, 1'b1, "t4");
        check_event("t4", 10'd1017, 16, 4'b1111);

        // T5: empty mask, then zero samples.
        start_event(10'd5, 10'd10, 10'd5, 4'b0000);
        wait_done(50, 1'b0, "t5a");
        check_event("t5a", 10'd1019, 5, 4'b0000);
        chk("t5a_tvalid_cycles", 32'(tv_cycles), 32'd0);
        start_event(10'd5, 10'd10, 10'd0, 4'b1111);
        wait_done(50, 1'b0, "t5b");
        check_event("t5b", 10'd1019, 0, 4'b1111);
        chk("t5b_tvalid_cycles", 32'(tv_cycles), 32'd0);

        // T6a: data_ready late; a second start while busy must be ignored.
        data_ready = 1'b0;
        start_event(10'd50, 10'd20, 10'd5, 4'b0100);
        repeat (5) @(posedge clk);
        #1;
        chk("t6_busy_waiting", 32'(busy), 32'd1);
        wraddress_triggerpoint = 10'd900; triggerpoint = 10'd0; nsmp = 10'd2; chanmask = 4'b0001;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        chk("t6_no_rden_before_ready", 32'(rden_seen), 32'd0);
        data_ready = 1'b1;
        wait_done(200, 1'b0, "t6a");
        check_event("t6a", 10'd30, 5, 4'b0100);

        // T6b: reset in the middle of READ with the sink stalled.
        tready = 1'b0;
        start_event(10'd0, 10'd0, 10'd16, 4'b1111);
        tready = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("t6b_reads_started", 32'(rden_seen), 32'd1);
        chk("t6b_busy_mid", 32'(busy), 32'd1);
        chk("t6b_tvalid_mid", 32'(tvalid), 32'd1);
        reset = 1'b1;
        #1;
        check_reset("t6b_async");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tready = 1'b1;
        clear_mon();
        repeat (6) @(posedge clk);
        #1;
        chk("t6b_no_bytes_after_reset", 32'(tv_cycles), 32'd0);
        chk("t6b_no_reads_after_reset", 32'(rden_seen), 32'd0);
        start_event(10'd5, 10'd10, 10'd4, 4'b0001);
        wait_done(200, 1'b0, "t6c");
        check_event("t6c", 10'd1019, 4, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
